exu_mdu: RTL and testbench
==========================

Name: exu_mdu

Overview:
- Parametrised multi-cycle multiply/divide execute unit for the RV M extension (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the single-cycle ALU in the execute stage. The EXU routes M-type instructions here and stalls until the result returns.
- Uses the same reqValid/respValid handshake style as the EXU, extended with ready signals and a kill input for pipeline flushes.

Parameters:
- XLEN, 32, operand and result width in bits; must be even and at least 8.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- reqValid  input  1  operation request valid
- reqReady  output  1  unit can accept a request
- kill  input  1  abort the in-flight operation (flush)
- mdu_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rdata1  input  XLEN  rs1 operand
- rdata2  input  XLEN  rs2 operand
- respValid  output  1  result valid
- respReady  input  1  consumer accepts result
- mdu_res  output  XLEN  result
- busy  output  1  state != MDU_IDLE

Behaviour:
- Reset (clock and reset are the only clock/reset; reset is synchronous, active-high): state MDU_IDLE, reqReady=1, respValid=0, mdu_res=0, busy=0, counter=0.
- States: MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE.
  - IDLE: reqReady=1. Accept occurs when reqValid&&reqReady at a clock edge.
  - On accept with a MUL op: go to MUL. With a DIV op: go to DIV, unless it is a special case, which goes straight to DONE.
- Operand latch at accept:
  - Signed operands are converted to magnitudes.
  - Sign flags are recorded. rs1 is signed for MULH, MULHSU, DIV, REM; rs2 is signed for MULH, DIV, REM.
  - The result-negate flag is the XOR of the two signs for mul/div; for REM it is the dividend sign.
- MUL: shift-add, one multiplier bit per cycle, with a 2*XLEN product register. Runs for exactly XLEN cycles, then goes to DONE.
- DIV: restoring division, one quotient bit per cycle, with an XLEN+1 bit partial remainder. Runs for exactly XLEN cycles, then goes to DONE.
- DONE: result is registered on entry and respValid=1. Hold until respReady is seen at a clock edge, then return to IDLE. reqReady=0 in DONE, so there is no back-to-back overlap.
- Latency:
  - Normal op: accept edge, then XLEN iteration edges, then respValid high. respValid is first visible XLEN+1 cycles after the accept cycle (33 for XLEN=32).
  - Special case: respValid is visible 1 cycle after accept.
- Result select:
  - MUL: low XLEN bits of the signed-corrected product.
  - MULH, MULHSU, MULHU: high XLEN bits.
  - DIV, DIVU: quotient. REM, REMU: remainder.
  - Negation is two's complement over the full 2*XLEN product for MUL ops, or over XLEN for DIV ops.
- Special cases, resolved at accept with no iteration:
  - Divide by zero: DIV/DIVU result = all ones; REM/REMU result = rs1.
  - Signed overflow (rs1 = most negative value, rs2 = -1): DIV result = rs1; REM result = 0.
- kill: in any state, kill forces IDLE on the next edge. respValid drops, and no response is produced for the killed op.
  - kill in the same cycle as reqValid in IDLE: the request is not accepted.
  - kill has priority over respReady.
- reset mid-operation: returns to the reset values above on the next edge; the partial result is discarded.
- mdu_res holds its last value outside DONE; consumers qualify it with respValid.

Optional Feature:
- MDU_FAST_MUL_EN.
- Defined: MUL ops compute a single-cycle 2*XLEN product from the latched operands. MUL goes from accept directly to DONE, so respValid appears 1 cycle after accept. DIV is unchanged.
- Undefined: iterative XLEN-cycle multiply as above, with no hardware multiplier inferred.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), XLEN=32 -> mdu_res=0xFFFFFFEB (-21), respValid 33 cycles after accept; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- Signed division: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0; each with respValid 1 cycle after accept.
- Backpressure: respReady held low for 5 cycles in DONE -> respValid and mdu_res stable, reqReady=0; respReady=1 -> IDLE next cycle, reqReady=1.
- Kill and reset: kill at iteration 10 of DIV -> IDLE next edge, respValid never asserted, next request executes correctly; reset asserted mid-MUL -> all outputs at reset values after 1 edge.
- Feature and parameter: MDU_FAST_MUL_EN defined, MULH 0x80000000*0x80000000 -> 0x40000000 with 1-cycle latency; XLEN=16 build, DIVU 0xFFFF/0x0010 -> 0x0FFF after 17 cycles.

Source files
------------

// File: rtl/exu_mdu_if.sv
// Request/response bundle between the EXU and the M-extension unit.
// master = EXU side, slave = exu_mdu.
interface exu_mdu_if #(
    parameter int XLEN = 32
);
    logic            reqValid;
    logic            reqReady;
    logic            kill;
    logic [2:0]      mdu_op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            respValid;
    logic            respReady;
    logic [XLEN-1:0] mdu_res;
    logic            busy;

    modport master (
        output reqValid, kill, mdu_op, rdata1, rdata2, respReady,
        input  reqReady, respValid, mdu_res, busy
    );

    modport slave (
        input  reqValid, kill, mdu_op, rdata1, rdata2, respReady,
        output reqReady, respValid, mdu_res, busy
    );
endinterface

// File: rtl/exu_mdu.sv
// RV M-extension multiply/divide unit: shift-add multiply, restoring divide (MDU_FAST_MUL_EN: 1-cycle multiply).
// Latency: XLEN+1 cycles accept-to-respValid; 1 cycle for div special cases (and all muls with MDU_FAST_MUL_EN).
// Backpressure: result held in DONE until respReady; reqReady only in IDLE; kill aborts in any state.
module exu_mdu #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic     clock,
    input  logic     reset,
    exu_mdu_if.slave mdu
);
    typedef enum logic [1:0] {MDU_IDLE, MDU_MUL, MDU_DIV, MDU_DONE} state_t;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [1:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quot;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   res_q;

    // Request decode, evaluated against the live request operands.
    logic            acc, in_mul, rs1_sgn, rs2_sgn, neg_in;
    logic            div_zero, div_ovf, special, last;
    logic [XLEN-1:0] mag1, mag2, spec_res;

    assign acc      = mdu.reqValid && (state == MDU_IDLE) && !mdu.kill;
    assign in_mul   = !mdu.mdu_op[2];
    assign rs1_sgn  = mdu.rdata1[XLEN-1] && (mdu.mdu_op == 3'd1 || mdu.mdu_op == 3'd2 ||
                                             mdu.mdu_op == 3'd4 || mdu.mdu_op == 3'd6);
    assign rs2_sgn  = mdu.rdata2[XLEN-1] && (mdu.mdu_op == 3'd1 || mdu.mdu_op == 3'd4 ||
                                             mdu.mdu_op == 3'd6);
    assign mag1     = rs1_sgn ? -mdu.rdata1 : mdu.rdata1;
    assign mag2     = rs2_sgn ? -mdu.rdata2 : mdu.rdata2;
    // Remainder takes the dividend's sign; everything else the product of signs.
    assign neg_in   = (mdu.mdu_op[2] && mdu.mdu_op[1]) ? rs1_sgn : (rs1_sgn ^ rs2_sgn);
    assign div_zero = (mdu.rdata2 == '0);
    assign div_ovf  = !mdu.mdu_op[0] && (mdu.rdata1 == MOST_NEG) && (mdu.rdata2 == '1);
    assign special  = mdu.mdu_op[2] && (div_zero || div_ovf);
    assign spec_res = div_zero ? (mdu.mdu_op[1] ? mdu.rdata1 : '1)
                               : (mdu.mdu_op[1] ? '0 : mdu.rdata1);
    assign last     = (cnt == CNT_W'(XLEN - 1));

    // Shift-add step: conditionally add multiplicand to the upper half, shift right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_nxt, prod_fix;
    logic [XLEN-1:0]   mul_res;

    assign mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, {XLEN{prod[0]}} & opb_q};
    assign prod_nxt = {mul_sum, prod[XLEN-1:1]};
    assign prod_fix = neg_q ? -prod_nxt : prod_nxt;
    assign mul_res  = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];

    // Restoring step: the XLEN+1 bit trial remainder's sign decides the quotient bit.
    logic [XLEN:0]   rem_sh, rem_try;
    logic [XLEN-1:0] rem_nxt, quot_nxt, div_raw, div_res;

    assign rem_sh   = {rem, quot[XLEN-1]};
    assign rem_try  = rem_sh - {1'b0, opb_q};
    assign rem_nxt  = rem_try[XLEN] ? rem_sh[XLEN-1:0] : rem_try[XLEN-1:0];
    assign quot_nxt = {quot[XLEN-2:0], !rem_try[XLEN]};
    assign div_raw  = op_q[1] ? rem_nxt : quot_nxt;
    assign div_res  = neg_q ? -div_raw : div_raw;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod, fast_fix;
    logic [XLEN-1:0]   fast_res;

    assign fast_prod = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
    assign fast_fix  = neg_in ? -fast_prod : fast_prod;
    assign fast_res  = (mdu.mdu_op == 3'd0) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= MDU_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MDU_IDLE: begin
                if (acc) begin
`ifdef MDU_FAST_MUL_EN
                    if (in_mul)       state_nxt = MDU_DONE;
`else
                    if (in_mul)       state_nxt = MDU_MUL;
`endif
                    else if (special) state_nxt = MDU_DONE;
                    else              state_nxt = MDU_DIV;
                end
            end
            MDU_MUL:  if (last) state_nxt = MDU_DONE;
            MDU_DIV:  if (last) state_nxt = MDU_DONE;
            MDU_DONE: if (mdu.respReady) state_nxt = MDU_IDLE;
            default:  state_nxt = MDU_IDLE;
        endcase
        if (mdu.kill) state_nxt = MDU_IDLE;
    end

    always_comb begin
        mdu.reqReady  = (state == MDU_IDLE);
        mdu.respValid = (state == MDU_DONE);
        mdu.busy      = (state != MDU_IDLE);
    end

    assign mdu.mdu_res = res_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q  <= '0;
            neg_q <= 1'b0;
            opb_q <= '0;
            prod  <= '0;
            rem   <= '0;
            quot  <= '0;
            cnt   <= '0;
            res_q <= '0;
        end else if (mdu.kill) begin
            cnt <= '0;
        end else begin
            unique case (state)
                MDU_IDLE: begin
                    if (acc) begin
                        op_q  <= mdu.mdu_op[1:0];
                        neg_q <= neg_in;
                        opb_q <= mag2;
                        prod  <= {{XLEN{1'b0}}, mag1};
                        rem   <= '0;
                        quot  <= mag1;
                        cnt   <= '0;
                        if (special) res_q <= spec_res;
`ifdef MDU_FAST_MUL_EN
                        if (in_mul)  res_q <= fast_res;
`endif
                    end
                end
                MDU_MUL: begin
                    prod <= prod_nxt;
                    cnt  <= last ? '0 : cnt + 1'b1;
                    if (last) res_q <= mul_res;
                end
                MDU_DIV: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= last ? '0 : cnt + 1'b1;
                    if (last) res_q <= div_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_mdu.sv
// Directed-vector bench for exu_mdu: stimulus pushes expected results and response cycles,
// a negedge monitor pops and compares on each accepted response.
module tb_exu_mdu;
    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int ML = 1;
`else
    localparam int ML = XLEN + 1;
`endif
    localparam int DL = XLEN + 1;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [7:0]  lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    localparam int NV = 17;
    localparam vec_t VECS [NV] = '{
        '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8'(ML)},
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'(ML)},
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 8'(ML)},
        '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 8'(ML)},
        '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 8'(ML)},
        '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'(DL)},
        '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'(DL)},
        '{3'd5, 32'd100,      32'd7,        32'd14,       8'(DL)},
        '{3'd7, 32'd100,      32'd7,        32'd2,        8'(DL)},
        '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 8'(DL)},
        '{3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        8'(DL)},
        '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd1},
        '{3'd6, 32'd5,        32'd0,        32'd5,        8'd1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        8'd1},
        '{3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        8'(DL)},
        '{3'd7, 32'd5,        32'd0,        32'd5,        8'd1}
    };

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    exu_mdu_if #(.XLEN(32)) mif ();
    exu_mdu_if #(.XLEN(16)) mif16 ();

    exu_mdu #(.XLEN(32)) dut (.clock(clock), .reset(reset), .mdu(mif));
    exu_mdu #(.XLEN(16)) dut16 (.clock(clock), .reset(reset), .mdu(mif16));

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name, input bit track);
        int n;
        n = 0;
        @(negedge clock);
        while (!mif.reqReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!mif.reqReady) begin
            check({name, " ready timeout"}, 32'd0, 32'd1);
            return;
        end
        mif.reqValid = 1'b1;
        mif.mdu_op   = op;
        mif.rdata1   = a;
        mif.rdata2   = b;
        if (track) sb.push_back('{exp, cyc + lat, name});
        @(posedge clock);
        #1 mif.reqValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    bit prev_vld = 1'b0;
    int first_cyc = 0;
    always @(negedge clock) begin
        if (reset) begin
            prev_vld = 1'b0;
        end else begin
            if (mif.respValid && !prev_vld) begin
                first_cyc = cyc;
                if (sb.size() == 0) check("unexpected resp", 32'd1, 32'd0);
            end
            if (mif.respValid && mif.respReady && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " res"}, mif.mdu_res, e.res);
                check({e.name, " lat"}, 32'(first_cyc), 32'(e.cyc));
            end
            prev_vld = mif.respValid;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int c0;
        int n;
        mif.reqValid = 1'b0; mif.kill = 1'b0; mif.mdu_op = 3'd0;
        mif.rdata1 = '0; mif.rdata2 = '0; mif.respReady = 1'b1;
        mif16.reqValid = 1'b0; mif16.kill = 1'b0; mif16.mdu_op = 3'd0;
        mif16.rdata1 = '0; mif16.rdata2 = '0; mif16.respReady = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset reqReady", 32'(mif.reqReady), 32'd1);
        check("reset respValid", 32'(mif.respValid), 32'd0);
        check("reset busy", 32'(mif.busy), 32'd0);
        check("reset mdu_res", mif.mdu_res, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            issue(VECS[i].op, VECS[i].a, VECS[i].b, VECS[i].r, int'(VECS[i].lat),
                  $sformatf("v%0d op%0d", i, VECS[i].op), 1'b1);
            drain();
        end

        // Hold the result with respReady low.
        mif.respReady = 1'b0;
        issue(3'd5, 32'd100, 32'd7, 32'd14, DL, "bp divu", 1'b1);
        n = 0;
        while (!mif.respValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("bp respValid arrives", 32'(mif.respValid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("bp hold%0d respValid", k), 32'(mif.respValid), 32'd1);
            check($sformatf("bp hold%0d mdu_res", k), mif.mdu_res, 32'd14);
            check($sformatf("bp hold%0d reqReady", k), 32'(mif.reqReady), 32'd0);
        end
        @(posedge clock);
        #1 mif.respReady = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("bp release reqReady", 32'(mif.reqReady), 32'd1);
        check("bp release respValid", 32'(mif.respValid), 32'd0);

        // Kill mid-divide: no response, unit free again.
        issue(3'd5, 32'd1000, 32'd3, 32'd0, DL, "killed div", 1'b0);
        repeat (10) @(posedge clock);
        #1 mif.kill = 1'b1;
        @(posedge clock);
        #1 mif.kill = 1'b0;
        @(negedge clock);
        check("kill busy", 32'(mif.busy), 32'd0);
        check("kill reqReady", 32'(mif.reqReady), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (mif.respValid) seen++;
        end
        check("kill no response", 32'(seen), 32'd0);
        issue(3'd5, 32'd1000, 32'd3, 32'd333, DL, "after kill divu", 1'b1);
        drain();

        // Kill together with a request: nothing accepted.
        @(negedge clock);
        mif.reqValid = 1'b1; mif.kill = 1'b1; mif.mdu_op = 3'd4;
        mif.rdata1 = 32'd9; mif.rdata2 = 32'd3;
        @(posedge clock);
        #1 mif.reqValid = 1'b0; mif.kill = 1'b0;
        @(negedge clock);
        check("kill+req not accepted", 32'(mif.busy), 32'd0);

        // Reset in the middle of a multiply.
        issue(3'd0, 32'd3, 32'd5, 32'd0, ML, "reset mul", 1'b0);
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("midrst reqReady", 32'(mif.reqReady), 32'd1);
        check("midrst respValid", 32'(mif.respValid), 32'd0);
        check("midrst busy", 32'(mif.busy), 32'd0);
        check("midrst mdu_res", mif.mdu_res, 32'd0);
        reset = 1'b0;
        issue(3'd0, 32'd3, 32'd5, 32'd15, ML, "after reset mul", 1'b1);
        drain();

        // 16-bit instance: DIVU 0xFFFF / 0x0010.
        @(negedge clock);
        mif16.reqValid = 1'b1; mif16.mdu_op = 3'd5;
        mif16.rdata1 = 16'hFFFF; mif16.rdata2 = 16'h0010;
        c0 = cyc;
        @(posedge clock);
        #1 mif16.reqValid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!mif16.respValid && n < 60) begin
            @(negedge clock);
            n++;
        end
        check("x16 respValid", 32'(mif16.respValid), 32'd1);
        check("x16 latency", 32'(cyc - c0), 32'd17);
        check("x16 divu res", 32'(mif16.mdu_res), 32'h0FFF);
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
